// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: owns the architectural fetch PC, selects the next PC
// (reset vector, redirect, sequential) and tags the instruction returned
// by the one-cycle-latency IMEM with its PC and a valid bit.
// Optional build macro: FETCH_PERF_CNT_EN adds fetch_count / kill_count.
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h0000_2000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] fetch_pc,
  output logic [31:0] dec_pc,
  output logic        dec_valid,
  output logic        redirect_ack
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] kill_count
`endif
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_KILL = 2'd2;

  logic [31:0] r_fetch_pc;
  logic [31:0] r_dec_pc;
  logic        r_dec_valid;
  logic [1:0]  r_state;

  logic        w_take;
  logic [31:0] w_redirect_tgt;
  logic [31:0] w_next_pc;
  logic [1:0]  w_next_state;

  assign w_take         = redirect_valid & ~stall;
  assign w_redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

  // Redirect acknowledge: accepted only when not stalled and not in reset
  always_comb begin
    redirect_ack = w_take & ~reset;
  end

  // Next PC and next state for a non-stalled edge
  always_comb begin
    w_next_pc    = r_fetch_pc + PC_INC;
    w_next_state = ST_RUN;
    if (redirect_valid) begin
      w_next_pc = w_redirect_tgt;
    end
    // Any accepted redirect kills the slot fetched at the old PC; this also
    // covers a redirect arriving in BOOT, whose next returned slot is the
    // reset-vector fetch and therefore wrong-path.
    case (r_state)
      ST_BOOT,
      ST_RUN,
      ST_KILL: w_next_state = redirect_valid ? ST_KILL : ST_RUN;
      default: w_next_state = ST_BOOT;
    endcase
  end

  // Fetch state registers: reset > stall (hold) > advance
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc  <= RESET_PC;
      r_dec_pc    <= RESET_PC;
      r_dec_valid <= 1'b0;
      r_state     <= ST_BOOT;
    end else if (!stall) begin
      r_fetch_pc  <= w_next_pc;
      r_dec_pc    <= r_fetch_pc;
      r_state     <= w_next_state;
      r_dec_valid <= (w_next_state == ST_RUN);
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_kill_count;

  // Performance counters: count delivered valid slots and killed slots
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_count <= '0;
      r_kill_count  <= '0;
    end else if (!stall) begin
      if (r_dec_valid) r_fetch_count <= r_fetch_count + 32'd1;
      if (r_state == ST_KILL) r_kill_count <= r_kill_count + 32'd1;
    end
  end

  assign fetch_count = r_fetch_count;
  assign kill_count  = r_kill_count;
`endif

  assign fetch_pc  = r_fetch_pc;
  assign dec_pc    = r_dec_pc;
  assign dec_valid = r_dec_valid;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: scoreboard bench for fetch_pc_gen. A behavioural model
// pushes the expected post-edge outputs per cycle; they are popped and
// compared after the edge. Build with FETCH_PERF_CNT_EN to cover counters.
module tb_fetch_pc_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_pc;
  logic [31:0] dec_pc;
  logic        dec_valid;
  logic        redirect_ack;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] kill_count;
`endif

  always #5 clk = ~clk;

  fetch_pc_gen #(
    .RESET_PC(32'h0000_2000),
    .PC_INC  (32'd4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .fetch_pc      (fetch_pc),
    .dec_pc        (dec_pc),
    .dec_valid     (dec_valid),
    .redirect_ack  (redirect_ack)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count   (fetch_count),
    .kill_count    (kill_count)
`endif
  );

  typedef struct {
    logic [31:0] fpc;
    logic [31:0] dpc;
    logic        dv;
    logic [31:0] fc;
    logic [31:0] kc;
  } exp_t;

  exp_t q[$];

  int n_vec = 0;
  int n_err = 0;

  // model state: 0 boot, 1 run, 2 kill
  logic [31:0] m_fpc = 32'h0000_2000;
  logic [31:0] m_dpc = 32'h0000_2000;
  logic        m_dv  = 1'b0;
  int          m_st  = 0;
  logic [31:0] m_fc  = '0;
  logic [31:0] m_kc  = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // one clock: drive inputs, check ack, predict, clock, compare
  task automatic step(input logic rst, input logic st, input logic rv, input logic [31:0] rpc);
    exp_t e;
    reset = rst; stall = st; redirect_valid = rv; redirect_pc = rpc;
    #1;
    chk("redirect_ack", {31'd0, redirect_ack}, {31'd0, (rv && !st && !rst)});
    if (rst) begin
      m_fpc = 32'h0000_2000; m_dpc = 32'h0000_2000; m_dv = 1'b0; m_st = 0;
      m_fc = '0; m_kc = '0;
    end else if (!st) begin
      if (m_dv) m_fc = m_fc + 1;
      if (m_st == 2) m_kc = m_kc + 1;
      m_dpc = m_fpc;
      if (rv) begin
        m_fpc = {rpc[31:2], 2'b00};
        m_st  = 2;
      end else begin
        m_fpc = m_fpc + 32'd4;
        m_st  = 1;
      end
      m_dv = (m_st == 1);
    end
    e.fpc = m_fpc; e.dpc = m_dpc; e.dv = m_dv; e.fc = m_fc; e.kc = m_kc;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL scoreboard: got empty queue expected entry");
    end else begin
      e = q.pop_front();
      chk("fetch_pc", fetch_pc, e.fpc);
      chk("dec_pc", dec_pc, e.dpc);
      chk("dec_valid", {31'd0, dec_valid}, {31'd0, e.dv});
`ifdef FETCH_PERF_CNT_EN
      chk("fetch_count", fetch_count, e.fc);
      chk("kill_count", kill_count, e.kc);
`endif
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    @(negedge clk);
    // reset, with a redirect request that must not be acknowledged
    step(1, 0, 1, 32'h0000_7000);
    step(1, 1, 0, 0);
    chk("rst_fetch_pc", fetch_pc, 32'h0000_2000);
    chk("rst_dec_valid", {31'd0, dec_valid}, 32'd0);

    // release: 0x2004/0x2000 valid, then 0x2008/0x2004
    step(0, 0, 0, 0);
    chk("tp_fetch_pc", fetch_pc, 32'h0000_2004);
    chk("tp_dec_pc", dec_pc, 32'h0000_2000);
    step(0, 0, 0, 0);

    // three stalled cycles at fetch_pc 0x2008, then resume
    repeat (3) step(0, 1, 0, 0);
    chk("stall_fetch_pc", fetch_pc, 32'h0000_2008);
    step(0, 0, 0, 0);
    chk("resume_fetch_pc", fetch_pc, 32'h0000_200C);

    // unaligned redirect target, one killed slot
    step(0, 0, 1, 32'h0000_2103);
    chk("redir_fetch_pc", fetch_pc, 32'h0000_2100);
    step(0, 0, 0, 0);
    chk("redir_dec_pc", dec_pc, 32'h0000_2100);

    // redirect held across a 2-cycle stall, then accepted
    step(0, 1, 1, 32'h0000_2500);
    step(0, 1, 1, 32'h0000_2500);
    step(0, 0, 1, 32'h0000_2500);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // back-to-back redirects
    step(0, 0, 1, 32'h0000_3000);
    step(0, 0, 1, 32'h0000_4000);
    step(0, 0, 0, 0);
    chk("b2b_dec_pc", dec_pc, 32'h0000_4000);
    step(0, 0, 0, 0);

    // redirect to the current fetch_pc still kills
    step(0, 0, 1, fetch_pc);
    step(0, 0, 0, 0);

    // 32-bit wrap
    step(0, 0, 1, 32'hFFFF_FFF8);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("wrap_fetch_pc", fetch_pc, 32'h0000_0000);
    step(0, 0, 0, 0);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) < 3), $urandom);
    end

    // reset while in KILL with stall asserted
    step(0, 0, 0, 0);
    step(0, 0, 1, 32'h0000_5000);
    step(1, 1, 0, 0);
    chk("kill_rst_fetch_pc", fetch_pc, 32'h0000_2000);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // absolute time guard
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/fetch_pc_gen.md
Name: fetch_pc_gen

Overview:
PC generation and fetch-tracking stage that sits directly upstream of the instruction-memory interface in stage 1. It owns the architectural fetch PC, computes next-PC (sequential, redirect, reset vector), and tracks the one-cycle IMEM read latency. It tags the instruction arriving from IMEM with its PC and a valid bit so the decode stage can discard wrong-path or bubble slots.

Parameters:
RESET_PC, 32'h0000_2000, fetch address loaded on reset
PC_INC, 4, sequential increment in bytes

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
stall  input  1  pipeline stall; freezes all fetch state
redirect_valid  input  1  taken branch/jump/trap redirect request from execute
redirect_pc  input  32  redirect target
fetch_pc  output  32  PC presented to IMEM this cycle (drives IMEM pc input)
dec_pc  output  32  PC of the instruction IMEM is returning this cycle
dec_valid  output  1  instruction returned this cycle is real and on the correct path
redirect_ack  output  1  redirect accepted this cycle (combinational: redirect_valid & ~stall & ~reset)

Behaviour:
- Clocking: clk. Reset: reset, synchronous, active-high. All registers update only on posedge clk.
- Reset values: fetch_pc=RESET_PC, dec_pc=RESET_PC, dec_valid=0, state=BOOT. redirect_ack is 0 while reset=1.
- Next-PC priority, evaluated each posedge: reset > stall (hold everything) > redirect_valid (fetch_pc <= {redirect_pc[31:2],2'b00}) > sequential (fetch_pc <= fetch_pc + PC_INC, 32-bit wrap, 0xFFFF_FFFC+4 -> 0).
- A redirect is sampled only when stall=0. The source holds redirect_valid/redirect_pc until redirect_ack=1. A redirect during stall has no effect until stall deasserts.
- Latency: fetch_pc=A in cycle n -> dec_pc=A in cycle n+1 (IMEM synchronous read). On a non-stalled posedge, dec_pc <= fetch_pc. On a stalled posedge, dec_pc holds.
- States:
  - BOOT: entered on reset. First cycle after reset. No instruction returning; dec_valid=0. Non-stalled posedge -> RUN.
  - RUN: dec_valid=1. Redirect accepted -> KILL. Otherwise stays in RUN.
  - KILL: dec_valid=0, because the slot returned is the fetch at the old PC (wrong path). Non-stalled posedge with no redirect -> RUN. Another redirect accepted -> stays in KILL.
  - Stall in any state: state and dec_valid hold.
- dec_valid is a registered output derived from next-state (RUN -> 1, BOOT/KILL -> 0).
- Redirect accepted in the same cycle as dec_valid=1: the current dec slot is still valid (it is older than the branch). Only the following slot is killed.
- Reset asserted mid-operation, including during stall or KILL: takes effect at the next posedge regardless of other inputs.
- Redirect target equal to the current fetch_pc is treated as a normal redirect; the kill still applies.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds outputs fetch_count[31:0] and kill_count[31:0], both reset to 0 and wrapping at 2^32.
  - fetch_count increments on each non-stalled posedge where dec_valid=1.
  - kill_count increments on each non-stalled posedge where the state is KILL.
  - Both hold during stall.
- Undefined: neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Reset then release, no stall -> cycle0 fetch_pc=0x2000, dec_valid=0; cycle1 fetch_pc=0x2004, dec_pc=0x2000, dec_valid=1; cycle2 dec_pc=0x2004.
- Stall held 3 cycles while fetch_pc=0x2008 -> fetch_pc=0x2008, dec_pc=0x2004, dec_valid=1 constant for all 3 cycles; sequence resumes 0x200C after release.
- redirect_valid=1, redirect_pc=0x2103 at fetch_pc=0x2008 -> redirect_ack=1; next cycle fetch_pc=0x2100, dec_pc=0x2008, dec_valid=0; following cycle dec_pc=0x2100, dec_valid=1.
- Redirect asserted during 2-cycle stall -> redirect_ack=0 and no PC change while stalled; accepted on the first unstalled cycle, then one killed slot.
- Back-to-back redirects to 0x3000 then 0x4000 -> dec_valid stays 0 across both; first valid slot is dec_pc=0x4000.
- Reset asserted while in KILL with stall=1 -> next cycle fetch_pc=0x2000, dec_valid=0, state BOOT. With FETCH_PERF_CNT_EN: both counters read 0.
